fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Multi-instruction fetch front end. It owns the PC and issues aligned fetch-group requests to the I-cache.
//  Returned words are buffered in a circular instruction queue, tagged with PC/pcplus4 and exception flags.
//  Decode drains up to DEQ_WIDTH entries per cycle. Sits between pcselect/I-cache and the decode register.
//  Generalises the single-instruction fetch stage with a width-parametrised group, buffering and flush recovery.
// PARAMETERS
//  FETCH_WIDTH  2             instructions per I-cache response (power of 2, 1..4)
//  DEPTH        8             queue entries (power of 2, >= 2*FETCH_WIDTH)
//  DEQ_WIDTH    2             max entries presented/consumed per cycle (<= DEPTH)
//  RESET_PC     32'hbfc00000  PC after reset
// PORTS
//  clk           in   1                 clock
//  resetn        in   1                 asynchronous active-low reset
//  ireq_valid    out  1                 fetch request valid
//  ireq_addr     out  32                group address, aligned to FETCH_WIDTH*4
//  ireq_ready    in   1                 I-cache accepts request
//  iresp_valid   in   1                 response valid (exactly one per accepted request, >= 1 cycle later)
//  iresp_data    in   32*FETCH_WIDTH    lane i = word at ireq_addr+4*i
//  i_tlb_invalid/i_tlb_modified/i_tlb_refill  in  1 each  TLB status, qualified by iresp_valid
//  is_usermode   in   1                 current privilege
//  flush         in   1                 redirect; has priority over every other event
//  redirect_pc   in   32                new PC, qualified by flush
//  out_valid     out  DEQ_WIDTH         valid entries (always a contiguous prefix from lane 0)
//  out_pc/out_pcplus4/out_instr  out  32*DEQ_WIDTH  per-lane PC, PC+4, raw instruction
//  out_exc       out  4*DEQ_WIDTH       per lane {exception_instr, tlb_invalid, tlb_modified, tlb_refill}
//  deq_count     in   $clog2(DEQ_WIDTH+1)  entries consumed this cycle; must be <= popcount(out_valid)
//  perf_full_cyc/perf_drop_cnt  out  32 each  performance counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset:
//  - pc=RESET_PC, queue empty, state=REQ, halted=0, counters=0.
//  - All outputs 0, except that ireq_valid follows the REQ rules.
//  FSM REQ:
//  - If pc is illegal (pc[1:0]!=0, or is_usermode & pc[31]):
//    - No request is issued.
//    - If the queue is not full, enqueue one entry {pc, raw_instr=0, exception_instr=1}, then set halted.
//  - Else ireq_valid=!halted & (free slots >= FETCH_WIDTH), with ireq_addr=pc & ~(FETCH_WIDTH*4-1).
//  - On ireq_valid & ireq_ready -> WAIT.
//  FSM WAIT:
//  - On iresp_valid, enqueue lanes from k=pc[log2(FETCH_WIDTH)+1:2] up to FETCH_WIDTH-1, in order.
//    - Entry j carries pc = base+4*j and pcplus4 = pc+4.
//  - pc <= base + FETCH_WIDTH*4, 32-bit wrap-around allowed. State -> REQ.
//  - If any TLB flag is set, enqueue only lane k with all three flags copied, and set halted.
//  FSM DROP:
//  - Entered when flush arrives while in WAIT, or in the same cycle as an ireq handshake.
//  - The next iresp_valid is discarded (perf_drop_cnt++), then -> REQ.
//  - A further flush while in DROP only updates pc.
//  Flush:
//  - Next cycle: queue empty, out_valid=0, pc=redirect_pc, halted=0.
//  - Same-cycle enqueue and dequeue are ignored.
//  - From REQ with no handshake -> REQ.
//  Queue:
//  - Read/write pointers of width log2(DEPTH), wrapping.
//  - Count is $clog2(DEPTH+1) bits. Enqueue and dequeue in the same cycle are legal.
//  - Enqueue never exceeds DEPTH, guaranteed by the free-slot check at request time.
//  - Outputs come combinationally from the head: out_valid[i] = (count > i).
//  - Latency: response cycle -> entry visible at out_* in the next cycle (queue was empty).
//  - Empty: out_valid=0, deq_count ignored. Full: ireq_valid=0.
//  Constraint:
//  - iresp_valid outside WAIT/DROP is a protocol error. Covered by an assertion; RTL ignores it.
//  Reset mid-operation:
//  - An outstanding request is forgotten.
//  - The I-cache is reset by the same resetn.
// CONFIGURATION
//  FETCH_QUEUE_PERF_EN defined:
//  - perf_full_cyc counts cycles with the queue full and no flush.
//  - perf_drop_cnt counts discarded responses.
//  - Both are 32-bit, saturating at 32'hffffffff, and reset to 0.
//  FETCH_QUEUE_PERF_EN undefined:
//  - No counter flops are built; both ports are tied to 32'h0. All other behaviour is identical.
// TESTING
//  T1 reset:
//  - Release resetn, ireq_ready=1 -> ireq_valid=1 with ireq_addr=32'hbfc00000.
//  - Response {A,B} -> next cycle out_valid=2'b11, out_pc={bfc00004,bfc00000}, out_instr lanes A,B.
//  T2 unaligned group:
//  - flush with redirect_pc=32'h80000004 -> req 32'h80000000.
//  - Response -> only lane1 enqueued (pc 80000004); next req 32'h80000008.
//  T3 flush during WAIT:
//  - flush with redirect_pc=32'h80001000 while a request is outstanding.
//  - Its response is dropped; next req 32'h80001000; perf_drop_cnt=1 (PERF_EN) or 0 (no PERF_EN).
//  T4 exceptions:
//  - redirect_pc=32'h80000002 -> no ireq.
//  - One entry with out_exc[3]=1, then halted until next flush.
//  - is_usermode=1 with pc=32'h80000000 -> same result.
//  T5 TLB refill:
//  - Response with i_tlb_refill=1 -> a single entry with out_exc=4'b0001; no further ireq until flush.
//  T6 backpressure:
//  - Hold deq_count=0 -> queue fills to 8; ireq_valid=0; perf_full_cyc increments each cycle.
//  - Then deq_count=2 -> requests resume once free >= 2; order and PCs are preserved across the pointer wrap.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch front end: owns the PC, issues aligned group requests and buffers returned words for decode.
// Optional performance counters are built only when FETCH_QUEUE_PERF_EN is defined.
module fetch_queue #(
    parameter int          FETCH_WIDTH = 2,
    parameter int          DEPTH       = 8,
    parameter int          DEQ_WIDTH   = 2,
    parameter logic [31:0] RESET_PC    = 32'hbfc00000
) (
    input  logic                             clk,
    input  logic                             resetn,
    output logic                             ireq_valid,
    output logic [31:0]                      ireq_addr,
    input  logic                             ireq_ready,
    input  logic                             iresp_valid,
    input  logic [32*FETCH_WIDTH-1:0]        iresp_data,
    input  logic                             i_tlb_invalid,
    input  logic                             i_tlb_modified,
    input  logic                             i_tlb_refill,
    input  logic                             is_usermode,
    input  logic                             flush,
    input  logic [31:0]                      redirect_pc,
    output logic [DEQ_WIDTH-1:0]             out_valid,
    output logic [32*DEQ_WIDTH-1:0]          out_pc,
    output logic [32*DEQ_WIDTH-1:0]          out_pcplus4,
    output logic [32*DEQ_WIDTH-1:0]          out_instr,
    output logic [4*DEQ_WIDTH-1:0]           out_exc,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]   deq_count,
    output logic [31:0]                      perf_full_cyc,
    output logic [31:0]                      perf_drop_cnt
);

    localparam int          PW       = $clog2(DEPTH);
    localparam int          CW       = $clog2(DEPTH + 1);
    localparam logic [31:0] GRP_MASK = 32'(FETCH_WIDTH * 4 - 1);

    typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

    state_t          state, state_nxt;
    logic [31:0]     pc, pc_nxt;
    logic            halted, halted_nxt;
    logic [PW-1:0]   rd_ptr, wr_ptr, rd_idx;
    logic [CW-1:0]   count, free_slots, enq_n, deq_eff;

    logic [31:0]     mem_pc    [DEPTH];
    logic [31:0]     mem_instr [DEPTH];
    logic [3:0]      mem_exc   [DEPTH];

    logic [31:0]     enq_pc    [FETCH_WIDTH];
    logic [31:0]     enq_instr [FETCH_WIDTH];
    logic [3:0]      enq_exc   [FETCH_WIDTH];

    logic [31:0]     base, k_off;
    logic [32*FETCH_WIDTH-1:0] lanes;
    logic            pc_illegal, full, tlb_any, hs;

    assign base       = pc & ~GRP_MASK;
    assign k_off      = (pc & GRP_MASK) >> 2;
    assign pc_illegal = (pc[1:0] != 2'b00) || (is_usermode && pc[31]);
    assign free_slots = CW'(DEPTH) - count;
    assign full       = (count == CW'(DEPTH));
    assign tlb_any    = i_tlb_invalid || i_tlb_modified || i_tlb_refill;
    // Response lanes shifted so that lane k (the first wanted word) lands at index 0.
    assign lanes      = iresp_data >> (k_off * 32);

    assign ireq_valid = (state == REQ) && !pc_illegal && !halted && (free_slots >= CW'(FETCH_WIDTH));
    assign ireq_addr  = ireq_valid ? base : 32'h0;
    assign hs         = ireq_valid && ireq_ready;

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        halted_nxt = halted;
        enq_n      = '0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            enq_pc[j]    = base + ((k_off + 32'(j)) << 2);
            enq_instr[j] = lanes[j*32 +: 32];
            enq_exc[j]   = {1'b0, i_tlb_invalid, i_tlb_modified, i_tlb_refill};
        end
        case (state)
            REQ: begin
                if (pc_illegal) begin
                    if (!halted && !full) begin
                        enq_n        = CW'(1);
                        enq_pc[0]    = pc;
                        enq_instr[0] = 32'h0;
                        enq_exc[0]   = 4'b1000;
                        halted_nxt   = 1'b1;
                    end
                end else if (hs) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (iresp_valid) begin
                    enq_n      = tlb_any ? CW'(1) : CW'(32'(FETCH_WIDTH) - k_off);
                    halted_nxt = halted || tlb_any;
                    pc_nxt     = base + 32'(FETCH_WIDTH * 4);
                    state_nxt  = REQ;
                end
            end
            DROP: begin
                if (iresp_valid) state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
        // A redirect wins over everything; a request still in flight must have its response discarded.
        if (flush) begin
            pc_nxt     = redirect_pc;
            halted_nxt = 1'b0;
            enq_n      = '0;
            if (state == WAIT)     state_nxt = iresp_valid ? REQ : DROP;
            else if (state == REQ) state_nxt = hs ? DROP : REQ;
        end
    end

    always_comb begin
        if (flush)                       deq_eff = '0;
        else if (CW'(deq_count) > count) deq_eff = count;
        else                             deq_eff = CW'(deq_count);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= REQ;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            pc     <= pc_nxt;
            halted <= halted_nxt;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                rd_ptr <= rd_ptr + PW'(deq_eff);
                wr_ptr <= wr_ptr + PW'(enq_n);
                count  <= count + enq_n - deq_eff;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            if (CW'(j) < enq_n) begin
                mem_pc[wr_ptr + PW'(j)]    <= enq_pc[j];
                mem_instr[wr_ptr + PW'(j)] <= enq_instr[j];
                mem_exc[wr_ptr + PW'(j)]   <= enq_exc[j];
            end
        end
    end

    // Head lanes; invalid lanes read as zero so nothing stale leaks to decode.
    always_comb begin
        rd_idx      = rd_ptr;
        out_valid   = '0;
        out_pc      = '0;
        out_pcplus4 = '0;
        out_instr   = '0;
        out_exc     = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            rd_idx = rd_ptr + PW'(i);
            if (count > CW'(i)) begin
                out_valid[i]          = 1'b1;
                out_pc[i*32 +: 32]      = mem_pc[rd_idx];
                out_pcplus4[i*32 +: 32] = mem_pc[rd_idx] + 32'd4;
                out_instr[i*32 +: 32]   = mem_instr[rd_idx];
                out_exc[i*4 +: 4]       = mem_exc[rd_idx];
            end
        end
    end

    a_resp_in_req: assert property (@(posedge clk) disable iff (!resetn) !(iresp_valid && state == REQ));

`ifdef FETCH_QUEUE_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hffffffff) ? v + 32'd1 : v;
    endfunction

    logic        drop_evt;
    logic [31:0] full_cyc_q, drop_cnt_q;

    assign drop_evt = iresp_valid && ((state == DROP) || (state == WAIT && flush));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full_cyc_q <= 32'h0;
            drop_cnt_q <= 32'h0;
        end else begin
            full_cyc_q <= sat_inc(full_cyc_q, full && !flush);
            drop_cnt_q <= sat_inc(drop_cnt_q, drop_evt);
        end
    end

    assign perf_full_cyc = full_cyc_q;
    assign perf_drop_cnt = drop_cnt_q;
`else
    assign perf_full_cyc = 32'h0;
    assign perf_drop_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed cycle table, a backpressure/wrap sequence and a randomized run
// against a queue-based reference model with an I-cache responder.
module tb_fetch_queue;

    localparam int FW    = 2;
    localparam int DEPTH = 8;
    localparam int DQ    = 2;
`ifdef FETCH_QUEUE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        ireq_valid, ireq_ready;
    logic [31:0] ireq_addr;
    logic        iresp_valid;
    logic [63:0] iresp_data;
    logic        i_tlb_invalid, i_tlb_modified, i_tlb_refill;
    logic        is_usermode, flush;
    logic [31:0] redirect_pc;
    logic [1:0]  out_valid;
    logic [63:0] out_pc, out_pcplus4, out_instr;
    logic [7:0]  out_exc;
    logic [1:0]  deq_count;
    logic [31:0] perf_full_cyc, perf_drop_cnt;

    always #5 clk = ~clk;

    fetch_queue #(.FETCH_WIDTH(FW), .DEPTH(DEPTH), .DEQ_WIDTH(DQ), .RESET_PC(32'hbfc00000)) dut (
        .clk(clk), .resetn(resetn),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
        .iresp_valid(iresp_valid), .iresp_data(iresp_data),
        .i_tlb_invalid(i_tlb_invalid), .i_tlb_modified(i_tlb_modified), .i_tlb_refill(i_tlb_refill),
        .is_usermode(is_usermode), .flush(flush), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_pcplus4(out_pcplus4),
        .out_instr(out_instr), .out_exc(out_exc), .deq_count(deq_count),
        .perf_full_cyc(perf_full_cyc), .perf_drop_cnt(perf_drop_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        f;    logic [31:0] rpc;  logic rdy;  logic rv;
        logic [63:0] data; logic [2:0]  tlb;  logic um;   logic [1:0] deq;
        logic        e_rv; logic [31:0] e_addr; logic [1:0] e_ov;
        logic [31:0] e_pc0, e_pc1, e_in0, e_in1; logic [3:0] e_ex0;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic f, input logic [31:0] rpc, input logic rdy, input logic rv,
                                input logic [63:0] data, input logic [2:0] tlb, input logic um,
                                input logic [1:0] deq, input logic e_rv, input logic [31:0] e_addr,
                                input logic [1:0] e_ov, input logic [31:0] e_pc0, input logic [31:0] e_pc1,
                                input logic [31:0] e_in0, input logic [31:0] e_in1, input logic [3:0] e_ex0);
        vec_t v;
        v.f = f; v.rpc = rpc; v.rdy = rdy; v.rv = rv; v.data = data; v.tlb = tlb; v.um = um; v.deq = deq;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_ov = e_ov; v.e_pc0 = e_pc0; v.e_pc1 = e_pc1;
        v.e_in0 = e_in0; v.e_in1 = e_in1; v.e_ex0 = e_ex0;
        return v;
    endfunction

    // Reference model: instruction queue plus request bookkeeping.
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic [3:0] exc; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc, m_full, m_dropc;
    bit          m_halt, m_busy, m_drop;
    bit          pend;
    logic [31:0] pend_addr;
    int          lat;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hc3c30f0f;
    endfunction

    task automatic drive_idle();
        flush = 0; redirect_pc = 0; ireq_ready = 0; iresp_valid = 0; iresp_data = 0;
        i_tlb_invalid = 0; i_tlb_modified = 0; i_tlb_refill = 0; is_usermode = 0; deq_count = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 0;
        drive_idle();
        pend = 0; lat = 0;
        mq.delete();
        m_pc = 32'hbfc00000; m_halt = 0; m_busy = 0; m_drop = 0; m_full = 0; m_dropc = 0;
        repeat (2) @(negedge clk);
        chk("rst_ireq_valid", ireq_valid, 1);
        chk("rst_ireq_addr", ireq_addr, 32'hbfc00000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_perf", {perf_full_cyc, perf_drop_cnt}, 0);
        resetn = 1;
    endtask

    task automatic step_model(input bit want_flush, input logic [31:0] rpc, input bit rdy,
                              input bit um, input int deq_req, input bit allow_tlb);
        int          sz, d, k;
        bit          legal, e_rv, hs_m;
        logic [2:0]  tlb;
        logic [31:0] e_addr, base;
        logic [1:0]  e_ov;
        logic [63:0] e_pc, e_pp4, e_in;
        logic [7:0]  e_ex;
        ent_t        e;
        @(negedge clk);
        iresp_valid = pend && (lat == 0);
        iresp_data  = iresp_valid ? {word(pend_addr + 32'd4), word(pend_addr)} : 64'h0;
        tlb = 3'b000;
        if (iresp_valid && allow_tlb && ($urandom % 10 == 0)) tlb = 3'($urandom_range(1, 7));
        {i_tlb_invalid, i_tlb_modified, i_tlb_refill} = tlb;
        flush = want_flush && !iresp_valid;
        redirect_pc = rpc; ireq_ready = rdy; is_usermode = um;
        sz = mq.size();
        d = (deq_req > sz) ? sz : deq_req;
        if (d > DQ) d = DQ;
        deq_count = 2'(d);
        #1;
        legal  = (m_pc[1:0] == 2'b00) && !(um && m_pc[31]);
        e_rv   = !m_busy && legal && !m_halt && (DEPTH - sz >= FW);
        e_addr = e_rv ? (m_pc & ~32'(FW*4-1)) : 32'h0;
        e_ov = 0; e_pc = 0; e_pp4 = 0; e_in = 0; e_ex = 0;
        for (int i = 0; i < DQ; i++) begin
            if (i < sz) begin
                e_ov[i] = 1'b1;
                e_pc[i*32 +: 32]  = mq[i].pc;
                e_pp4[i*32 +: 32] = mq[i].pc + 32'd4;
                e_in[i*32 +: 32]  = mq[i].instr;
                e_ex[i*4 +: 4]    = mq[i].exc;
            end
        end
        chk("m_ireq_valid", ireq_valid, e_rv);
        chk("m_ireq_addr", ireq_addr, e_addr);
        chk("m_out_valid", out_valid, e_ov);
        chk("m_out_pc", out_pc, e_pc);
        chk("m_out_pcplus4", out_pcplus4, e_pp4);
        chk("m_out_instr", out_instr, e_in);
        chk("m_out_exc", out_exc, e_ex);
        chk("m_perf_full", perf_full_cyc, PERF ? m_full : 32'h0);
        chk("m_perf_drop", perf_drop_cnt, PERF ? m_dropc : 32'h0);
        // I-cache responder follows the DUT's real handshake.
        if (pend) begin
            if (lat == 0) pend = 0;
            else lat--;
        end
        if (ireq_valid && ireq_ready) begin
            pend = 1; pend_addr = ireq_addr; lat = $urandom_range(0, 2);
        end
        hs_m = e_rv && rdy;
        if (sz == DEPTH && !flush) m_full++;
        if (flush) begin
            mq.delete();
            m_pc = rpc; m_halt = 0;
            if (m_busy || hs_m) begin m_busy = 1; m_drop = 1; end
        end else begin
            for (int i = 0; i < d; i++) void'(mq.pop_front());
            if (iresp_valid) begin
                if (m_drop) begin
                    m_drop = 0; m_dropc++;
                end else begin
                    base = m_pc & ~32'(FW*4-1);
                    k = int'((m_pc % (FW*4)) / 4);
                    for (int j = k; j < FW; j++) begin
                        if (tlb == 0 || j == k) begin
                            e.pc = base + 32'(4*j); e.instr = iresp_data[j*32 +: 32]; e.exc = {1'b0, tlb};
                            mq.push_back(e);
                        end
                    end
                    if (tlb != 0) m_halt = 1;
                    m_pc = base + 32'(FW*4);
                end
                m_busy = 0;
            end else if (!m_busy && !legal) begin
                if (!m_halt && sz < DEPTH) begin
                    e.pc = m_pc; e.instr = 0; e.exc = 4'b1000;
                    mq.push_back(e);
                    m_halt = 1;
                end
            end else if (hs_m) begin
                m_busy = 1;
            end
        end
    endtask

    logic [31:0] r, rpc;
    bit          um, wf;

    initial begin
        resetn = 0;
        drive_idle();
        do_reset();

        // f rpc rdy rv data tlb um deq | rv addr ov pc0 pc1 in0 in1 ex0
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'hbfc00000, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 64'h22222222_11111111, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hbfc00008, 2'b11, 32'hbfc00000, 32'hbfc00004, 32'h11111111, 32'h22222222, 0));
        tbl.push_back(mk(1, 32'h80000004, 0, 0, 0, 0, 0, 0, 1, 32'hbfc00008, 2'b11, 32'hbfc00000, 32'hbfc00004, 32'h11111111, 32'h22222222, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h80000000, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 64'h44444444_33333333, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80000008, 2'b01, 32'h80000004, 0, 32'h44444444, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h80000008, 2'b01, 32'h80000004, 0, 32'h44444444, 0, 0));
        tbl.push_back(mk(1, 32'h80001000, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 64'h66666666_55555555, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h80001000, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h80000002, 0, 0, 0, 0, 0, 0, 1, 32'h80001000, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 32'h80000002, 0, 0, 0, 4'b1000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'b01, 32'h80000002, 0, 0, 0, 4'b1000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 32'h80000000, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 2'b01, 32'h80000000, 0, 0, 0, 4'b1000));
        tbl.push_back(mk(1, 32'h80000010, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h80000010, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 64'h88888888_77777777, 3'b001, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 32'h80000010, 0, 32'h77777777, 0, 4'b0001));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'b01, 32'h80000010, 0, 32'h77777777, 0, 4'b0001));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));

        for (int n = 0; n < tbl.size(); n++) begin
            @(negedge clk);
            flush = tbl[n].f; redirect_pc = tbl[n].rpc; ireq_ready = tbl[n].rdy;
            iresp_valid = tbl[n].rv; iresp_data = tbl[n].data;
            {i_tlb_invalid, i_tlb_modified, i_tlb_refill} = tbl[n].tlb;
            is_usermode = tbl[n].um; deq_count = tbl[n].deq;
            #1;
            chk($sformatf("t%0d_ireq_valid", n), ireq_valid, tbl[n].e_rv);
            chk($sformatf("t%0d_ireq_addr", n), ireq_addr, tbl[n].e_addr);
            chk($sformatf("t%0d_out_valid", n), out_valid, tbl[n].e_ov);
            chk($sformatf("t%0d_out_pc", n), out_pc, {tbl[n].e_pc1, tbl[n].e_pc0});
            chk($sformatf("t%0d_out_pcplus4", n), out_pcplus4,
                {tbl[n].e_ov[1] ? tbl[n].e_pc1 + 32'd4 : 32'h0, tbl[n].e_ov[0] ? tbl[n].e_pc0 + 32'd4 : 32'h0});
            chk($sformatf("t%0d_out_instr", n), out_instr, {tbl[n].e_in1, tbl[n].e_in0});
            chk($sformatf("t%0d_out_exc", n), out_exc, {4'b0000, tbl[n].e_ex0});
        end
        @(negedge clk);
        drive_idle();
        #1;
        chk("tbl_perf_drop", perf_drop_cnt, PERF ? 32'd1 : 32'd0);
        chk("tbl_perf_full", perf_full_cyc, 32'd0);

        // Backpressure: fill to DEPTH, then drain across the pointer wrap.
        do_reset();
        for (int n = 0; n < 30; n++) step_model(0, 0, 1, 0, 0, 0);
        chk("t6_full_ireq_valid", ireq_valid, 0);
        chk("t6_full_out_valid", out_valid, 2'b11);
        for (int n = 0; n < 40; n++) step_model(0, 0, 1, 0, 2, 0);

        // Random traffic, including a reset in the middle of operation.
        um = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            wf = ($urandom % 16 == 0);
            r = $urandom;
            case ($urandom % 8)
                0:       rpc = 32'hfffffff8 | {29'h0, r[0], 2'b00};
                1:       rpc = {r[31:2], 2'b10};
                default: rpc = {r[31:2], 2'b00};
            endcase
            if ($urandom % 8 == 0) um = ~um;
            step_model(wf, rpc, ($urandom % 4) != 0, um, $urandom_range(0, 2), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
